ddr4_rx_lane_align: RTL and testbench

DDR4_RX_LANE_ALIGN -- requirements
Module: ddr4_rx_lane_align

---
 rtl/ddr4_rx_lane_align.sv | 136 +++++++++++++
 tb/tb_ddr4_rx_lane_align.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_rx_lane_align.sv
// DDR4 RX lane training: bit-slip and delay-tap search until the lane delivers
// PATTERN for MATCH_CNT consecutive fabric cycles.
module ddr4_rx_lane_align #(
  parameter logic [3:0]  PATTERN   = 4'b1010,
  parameter int unsigned MATCH_CNT = 8,
  parameter int unsigned SETTLE    = 4,
  parameter int unsigned MAX_TAPS  = 127
) (
  input  logic       FAB_CLK,
  input  logic       RX_SYNC_RST,
  input  logic       TRAIN_START,
  input  logic [3:0] RX_DATA_0,
  input  logic       DELAY_LINE_OUT_OF_RANGE_0,
  output logic       RX_BIT_SLIP_0,
  output logic       DELAY_LINE_MOVE_0,
  output logic       DELAY_LINE_DIRECTION_0,
  output logic       DELAY_LINE_LOAD_0,
  output logic       BUSY,
  output logic       TRAIN_DONE,
  output logic       TRAIN_FAIL,
  output logic [6:0] TAP_COUNT,
  output logic [1:0] SLIP_COUNT
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_SLIP  = 3'd4;
  localparam logic [2:0] S_MOVE  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_FAIL  = 3'd7;

  localparam logic [3:0] MATCH_LIM = 4'(MATCH_CNT);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);
  localparam logic [6:0] TAP_LIM   = 7'(MAX_TAPS);

  logic [2:0] state_q, state_d;
  logic [6:0] tap_q, tap_d;
  logic [1:0] slip_q, slip_d;
  logic [3:0] match_q, match_d;
  logic [3:0] wait_q, wait_d;
  logic       busy;

  assign busy = (state_q == S_LOAD) || (state_q == S_WAIT) || (state_q == S_CHECK) ||
                (state_q == S_SLIP) || (state_q == S_MOVE);

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    slip_d  = slip_q;
    match_d = match_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (TRAIN_START) begin
          state_d = S_LOAD;
          tap_d   = '0;
          slip_d  = '0;
          match_d = '0;
        end
      end
      S_LOAD: begin
        state_d = S_WAIT;
        wait_d  = SETTLE_LD;
      end
      S_WAIT: begin
        if (wait_q <= 4'd1) begin
          state_d = S_CHECK;
          match_d = '0;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_CHECK: begin
        if (RX_DATA_0 == PATTERN) begin
          match_d = match_q + 4'd1;
          if (match_q + 4'd1 == MATCH_LIM) state_d = S_DONE;
        end else if (slip_q != 2'd3) begin
          state_d = S_SLIP;
        end else if (tap_q == TAP_LIM) begin
          state_d = S_FAIL;
        end else begin
          state_d = S_MOVE;
        end
      end
      S_SLIP: begin
        slip_d  = slip_q + 2'd1;
        state_d = S_WAIT;
        wait_d  = SETTLE_LD;
      end
      S_MOVE: begin
        tap_d   = tap_q + 7'd1;
        slip_d  = '0;
        state_d = S_WAIT;
        wait_d  = SETTLE_LD;
      end
      default: state_d = S_IDLE;
    endcase
    // Delay-line limit aborts training from any busy state with counters frozen.
    if (busy && DELAY_LINE_OUT_OF_RANGE_0) begin
      state_d = S_FAIL;
      tap_d   = tap_q;
      slip_d  = slip_q;
      match_d = match_q;
      wait_d  = wait_q;
    end
  end

  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
      slip_q  <= '0;
      match_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      slip_q  <= slip_d;
      match_q <= match_d;
      wait_q  <= wait_d;
    end
  end

  assign RX_BIT_SLIP_0          = (state_q == S_SLIP);
  assign DELAY_LINE_MOVE_0      = (state_q == S_MOVE);
  assign DELAY_LINE_LOAD_0      = (state_q == S_LOAD);
  assign DELAY_LINE_DIRECTION_0 = (state_q != S_IDLE);
  assign BUSY                   = busy;
  assign TRAIN_DONE             = (state_q == S_DONE);
  assign TRAIN_FAIL             = (state_q == S_FAIL);
  assign TAP_COUNT              = tap_q;
  assign SLIP_COUNT             = slip_q;

endmodule

// File: tb/tb_ddr4_rx_lane_align.sv
// Bench for ddr4_rx_lane_align: two instances (default, and PATTERN=0001/MAX_TAPS=5)
// driven by a small IOD model that rotates data on slips and tracks taps.
module tb_ddr4_rx_lane_align;

  localparam int M_CONST = 0;
  localparam int M_ROT   = 1;
  localparam int M_TAP   = 2;

  typedef struct {
    int         d;
    int         mode;
    logic [3:0] val;
    int         exp_done;
    int         exp_fail;
    int         exp_tap;
    int         exp_slip;
    int         exp_nslip;
    int         exp_nmove;
    int         exp_lat;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[2], start[2], oor[2];
  logic [3:0] rxd[2];
  logic       slp[2], mov[2], dir[2], ld[2], busy[2], done[2], fail[2];
  logic [6:0] tap[2];
  logic [1:0] sc[2];

  int         mode[2];
  logic [3:0] val[2];
  int rot[2], tapm[2], nslip[2], nmove[2], nload[2], baddir[2], multi[2];
  int last_slip[2], mingap[2];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  vec_t vecs[5];
  vec_t sb[$];

  ddr4_rx_lane_align dut0 (
    .FAB_CLK(clk), .RX_SYNC_RST(rst[0]), .TRAIN_START(start[0]), .RX_DATA_0(rxd[0]),
    .DELAY_LINE_OUT_OF_RANGE_0(oor[0]), .RX_BIT_SLIP_0(slp[0]), .DELAY_LINE_MOVE_0(mov[0]),
    .DELAY_LINE_DIRECTION_0(dir[0]), .DELAY_LINE_LOAD_0(ld[0]), .BUSY(busy[0]),
    .TRAIN_DONE(done[0]), .TRAIN_FAIL(fail[0]), .TAP_COUNT(tap[0]), .SLIP_COUNT(sc[0])
  );

  ddr4_rx_lane_align #(.PATTERN(4'b0001), .MAX_TAPS(5)) dut1 (
    .FAB_CLK(clk), .RX_SYNC_RST(rst[1]), .TRAIN_START(start[1]), .RX_DATA_0(rxd[1]),
    .DELAY_LINE_OUT_OF_RANGE_0(oor[1]), .RX_BIT_SLIP_0(slp[1]), .DELAY_LINE_MOVE_0(mov[1]),
    .DELAY_LINE_DIRECTION_0(dir[1]), .DELAY_LINE_LOAD_0(ld[1]), .BUSY(busy[1]),
    .TRAIN_DONE(done[1]), .TRAIN_FAIL(fail[1]), .TAP_COUNT(tap[1]), .SLIP_COUNT(sc[1])
  );

  function automatic logic [3:0] rotl(input logic [3:0] x, input int r);
    logic [3:0] y = x;
    for (int i = 0; i < r; i++) y = {y[2:0], y[3]};
    return y;
  endfunction

  // Lane model: each slip rotates the nibble, the delay line only lines up from tap 3.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      rxd[d] = val[d];
      case (mode[d])
        M_ROT:   rxd[d] = rotl(val[d], rot[d]);
        M_TAP:   rxd[d] = (tapm[d] >= 3) ? 4'b1010 : 4'b0000;
        default: rxd[d] = val[d];
      endcase
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rot[d] = 0; tapm[d] = 0; nslip[d] = 0; nmove[d] = 0; nload[d] = 0;
      baddir[d] = 0; multi[d] = 0; last_slip[d] = -1; mingap[d] = 1000;
    end
  end

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (int'(slp[d]) + int'(mov[d]) + int'(ld[d]) > 1) multi[d]++;
      if (ld[d] === 1'b1) begin
        nload[d]++; rot[d] = 0; tapm[d] = 0; last_slip[d] = -1; mingap[d] = 1000;
      end
      if (slp[d] === 1'b1) begin
        nslip[d]++;
        rot[d] = (rot[d] + 1) % 4;
        if (last_slip[d] >= 0 && cyc - last_slip[d] < mingap[d]) mingap[d] = cyc - last_slip[d];
        last_slip[d] = cyc;
      end
      if (mov[d] === 1'b1) begin
        nmove[d]++; tapm[d]++;
        if (dir[d] !== 1'b1) baddir[d]++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs(input int d);
    return int'({slp[d], mov[d], dir[d], ld[d], busy[d], done[d], fail[d], tap[d], sc[d]});
  endfunction

  task automatic run(input int idx, input vec_t v);
    int n, s0, m0, l0, b0, d;
    vec_t e;
    d = v.d;
    @(negedge clk);
    mode[d] = v.mode;
    val[d]  = v.val;
    s0 = nslip[d]; m0 = nmove[d]; l0 = nload[d]; b0 = baddir[d];
    sb.push_back(v);
    start[d] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      start[d] = 1'b0;
      n++;
    end while (!(done[d] || fail[d]) && n < 6000);
    e = sb.pop_front();
    chk($sformatf("v%0d_finished", idx), int'(done[d] || fail[d]), 1);
    chk($sformatf("v%0d_done", idx), int'(done[d]), e.exp_done);
    chk($sformatf("v%0d_fail", idx), int'(fail[d]), e.exp_fail);
    chk($sformatf("v%0d_tap", idx), int'(tap[d]), e.exp_tap);
    chk($sformatf("v%0d_slipcnt", idx), int'(sc[d]), e.exp_slip);
    chk($sformatf("v%0d_slip_pulses", idx), nslip[d] - s0, e.exp_nslip);
    chk($sformatf("v%0d_move_pulses", idx), nmove[d] - m0, e.exp_nmove);
    chk($sformatf("v%0d_load_pulses", idx), nload[d] - l0, 1);
    chk($sformatf("v%0d_busy", idx), int'(busy[d]), 0);
    chk($sformatf("v%0d_move_dir", idx), baddir[d] - b0, 0);
    if (e.exp_lat != 0) chk($sformatf("v%0d_latency", idx), n, e.exp_lat);
    if (e.exp_nslip >= 2) chk($sformatf("v%0d_slip_gap_ok", idx), int'(mingap[d] >= 5), 1);
  endtask

  initial begin
    int p0;
    vecs[0] = '{0, M_CONST, 4'b1010, 1, 0, 0, 0, 0, 0, 14};
    vecs[1] = '{1, M_ROT,   4'b0100, 1, 0, 0, 2, 2, 0, 0};
    vecs[2] = '{0, M_TAP,   4'b0000, 1, 0, 3, 0, 9, 3, 0};
    vecs[3] = '{1, M_CONST, 4'b0000, 0, 1, 5, 3, 18, 5, 0};
    vecs[4] = '{1, M_ROT,   4'b1000, 1, 0, 0, 1, 1, 0, 0};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; oor[d] = 1'b0; mode[d] = M_CONST; val[d] = 4'b0000;
    end
    repeat (3) @(negedge clk);
    chk("reset_outs_dut0", outs(0), 0);
    chk("reset_outs_dut1", outs(1), 0);
    // Reset wins over a simultaneous start request.
    start[0] = 1'b1;
    @(negedge clk);
    chk("reset_beats_start", outs(0), 0);
    start[0] = 1'b0;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    chk("idle_dir_low", int'(dir[0]), 0);

    for (int i = 0; i < 5; i++) run(i, vecs[i]);

    // Out-of-range raised while settling in WAIT.
    @(negedge clk);
    mode[0] = M_CONST; val[0] = 4'b0000;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    chk("oor_load_pulse", int'(ld[0]), 1);
    @(negedge clk);
    chk("oor_in_wait_busy", int'(busy[0]), 1);
    chk("oor_in_wait_nopulse", int'(ld[0]) + int'(slp[0]) + int'(mov[0]), 0);
    oor[0] = 1'b1;
    @(negedge clk);
    oor[0] = 1'b0;
    chk("oor_fail", int'(fail[0]), 1);
    chk("oor_busy", int'(busy[0]), 0);
    chk("oor_done", int'(done[0]), 0);
    chk("oor_tap", int'(tap[0]), 0);
    p0 = nslip[0] + nmove[0] + nload[0];
    repeat (8) @(negedge clk);
    chk("oor_no_more_pulses", nslip[0] + nmove[0] + nload[0] - p0, 0);
    chk("oor_fail_held", int'(fail[0]), 1);

    // Reset in CHECK after five matches, then a clean retrain.
    mode[0] = M_CONST; val[0] = 4'b1010;
    start[0] = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    chk("midrst_busy_before", int'(busy[0]), 1);
    chk("midrst_done_before", int'(done[0]), 0);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("midrst_outs_zero", outs(0), 0);
    run(5, vecs[0]);

    chk("one_pulse_at_a_time_dut0", multi[0], 0);
    chk("one_pulse_at_a_time_dut1", multi[1], 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
